// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the parameterised register file.
// Imported by regfile_clr_seq and regfile_param.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks an index over every register, one per cycle.
// Ports: Clk, Reset (sync, active-high), Clear_req in; Busy, clr_stb, clr_idx out.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear_req,
  output logic              Busy,
  output logic              clr_stb,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  clr_state_t        state_q;
  clr_state_t        state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Clear_req is only looked at in IDLE, so a request
  // during CLEAR neither restarts nor extends the walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    Busy    = 1'b0;
    clr_stb = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        Busy    = 1'b1;
        clr_stb = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign clr_idx = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Multi-read-port register file with per-register dirty bits and a sequential clear.
// Ports: Clk, Reset, Load, Write_sel, Data_In, Read_sel, Clear_req in; Data_out, Busy, Dirty, Reg_dump out. Macro REGFILE_BYPASS_EN enables write-to-read forwarding.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int NUM_RD   = DEF_NUM_RD,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Load,
  input  logic [ADDR_W-1:0]          Write_sel,
  input  logic [DATA_W-1:0]          Data_In,
  input  logic [NUM_RD*ADDR_W-1:0]   Read_sel,
  output logic [NUM_RD*DATA_W-1:0]   Data_out,
  input  logic                       Clear_req,
  output logic                       Busy,
  output logic [NUM_REGS-1:0]        Dirty,
  output logic [NUM_REGS*DATA_W-1:0] Reg_dump
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              clr_stb;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_en;

  regfile_clr_seq #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_clr_seq (
    .Clk       (Clk),
    .Reset     (Reset),
    .Clear_req (Clear_req),
    .Busy      (Busy),
    .clr_stb   (clr_stb),
    .clr_idx   (clr_idx)
  );

  // Writes are locked out for the whole clear walk.
  assign wr_en = Load && !Busy;

  // wr_en and clr_stb are mutually exclusive, so the
  // two updates below never target the same edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      Dirty <= '0;
    end else begin
      if (wr_en) begin
        regs[Write_sel]  <= Data_In;
        Dirty[Write_sel] <= 1'b1;
      end
      if (clr_stb) begin
        regs[clr_idx]  <= '0;
        Dirty[clr_idx] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    assign sel = Read_sel[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign Data_out[k*DATA_W +: DATA_W] =
      (wr_en && (sel == Write_sel)) ? Data_In : regs[sel];
`else
    assign Data_out[k*DATA_W +: DATA_W] = regs[sel];
`endif
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dump
    assign Reg_dump[i*DATA_W +: DATA_W] = regs[i];
  end

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile_param;

  localparam int DW  = 16;
  localparam int NR  = 8;
  localparam int NRD = 2;
  localparam int AW  = 3;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              Load;
  logic [AW-1:0]     Write_sel;
  logic [DW-1:0]     Data_In;
  logic [NRD*AW-1:0] Read_sel;
  logic [NRD*DW-1:0] Data_out;
  logic              Clear_req;
  logic              Busy;
  logic [NR-1:0]     Dirty;
  logic [NR*DW-1:0]  Reg_dump;

  regfile_param #(
    .DATA_W   (DW),
    .NUM_REGS (NR),
    .NUM_RD   (NRD)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Load      (Load),
    .Write_sel (Write_sel),
    .Data_In   (Data_In),
    .Read_sel  (Read_sel),
    .Data_out  (Data_out),
    .Clear_req (Clear_req),
    .Busy      (Busy),
    .Dirty     (Dirty),
    .Reg_dump  (Reg_dump)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [NR];
  logic [NR-1:0] m_dirty;
  bit            m_busy;
  int            m_idx;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input int k);
    logic [AW-1:0] a;
    a = Read_sel[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    if (Load && !m_busy && a == Write_sel) return Data_In;
`endif
    return m_regs[a];
  endfunction

  task automatic check_all();
    logic [NR*DW-1:0] d;
    chk("busy", Busy, m_busy);
    chk("dirty", Dirty, m_dirty);
    for (int k = 0; k < NRD; k++)
      chk($sformatf("rd%0d", k), Data_out[k*DW +: DW], exp_rd(k));
    for (int i = 0; i < NR; i++) d[i*DW +: DW] = m_regs[i];
    chk("dump", Reg_dump, d);
  endtask

  // Reference behaviour at a rising edge, from the inputs held this cycle.
  task automatic model_edge();
    if (Reset) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      m_dirty = '0;
      m_busy  = 0;
      m_idx   = 0;
    end else if (m_busy) begin
      m_regs[m_idx]  = '0;
      m_dirty[m_idx] = 1'b0;
      m_idx++;
      if (m_idx == NR) m_busy = 0;
    end else begin
      if (Load) begin
        m_regs[Write_sel]  = Data_In;
        m_dirty[Write_sel] = 1'b1;
      end
      if (Clear_req) begin
        m_busy = 1;
        m_idx  = 0;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_all();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input bit ld, input int ws, input logic [DW-1:0] d,
                        input int r0, input int r1, input bit cr,
                        input bit rs);
    Load      = ld;
    Write_sel = AW'(ws);
    Data_In   = d;
    Read_sel  = {AW'(r1), AW'(r0)};
    Clear_req = cr;
    Reset     = rs;
  endtask

  initial begin
    int bc;
    set_in(0, 0, 0, 0, 0, 0, 1);
    @(posedge Clk);
    model_edge();
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_dirty", Dirty, 0);
    chk("reset_dump", Reg_dump, 0);
    tick();

    // Basic write, same-cycle read on port 1, next-cycle read on port 0.
    set_in(1, 3, 16'hDC03, 0, 3, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_rd1", Data_out[31:16], 16'hDC03);
`else
    chk("same_cycle_rd1", Data_out[31:16], 16'h0000);
`endif
    tick();
    set_in(0, 0, 0, 3, 0, 0, 0);
    #1;
    chk("wr_rd0", Data_out[15:0], 16'hDC03);
    chk("wr_dirty", Dirty, 8'b0000_1000);
    tick();

    // Fill and clear.
    for (int i = 0; i < NR; i++) begin
      set_in(1, i, 16'(16'h1111 * (i + 1)), 0, 7, 0, 0);
      tick();
    end
    set_in(0, 0, 0, 0, 7, 1, 0);
    tick();
    set_in(0, 0, 0, 0, 7, 0, 0);
    bc = 0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (Busy) bc++;
      if (c == 1) chk("clr_c1_r0", Data_out[15:0], 16'h1111);
      if (c == 2) begin
        chk("clr_c2_r0", Data_out[15:0], 16'h0000);
        chk("clr_c2_r7", Data_out[31:16], 16'h8888);
      end
      tick();
    end
    chk("busy_len", bc, 8);
    chk("clr_dump", Reg_dump, 0);
    chk("clr_dirty", Dirty, 0);

    // Load during CLEAR is ignored.
    set_in(1, 5, 16'h1234, 5, 0, 0, 0);
    tick();
    set_in(0, 5, 0, 5, 0, 1, 0);
    tick();
    set_in(0, 5, 0, 5, 0, 0, 0);
    tick();
    set_in(1, 5, 16'hBEEF, 5, 0, 0, 0);
    tick();
    set_in(0, 5, 0, 5, 0, 0, 0);
    for (int c = 0; c < 8; c++) tick();
    chk("ld_in_clr_r5", Reg_dump[5*DW +: DW], 16'h0000);
    chk("ld_in_clr_dirty5", Dirty[5], 1'b0);

    // Reset on the 3rd clear cycle aborts the walk.
    set_in(1, 2, 16'h7777, 2, 6, 0, 0);
    tick();
    set_in(1, 6, 16'h6666, 2, 6, 0, 0);
    tick();
    set_in(0, 0, 0, 2, 6, 1, 0);
    tick();
    set_in(0, 0, 0, 2, 6, 0, 0);
    tick();
    tick();
    set_in(0, 0, 0, 2, 6, 0, 1);
    tick();
    set_in(0, 0, 0, 2, 6, 0, 0);
    #1;
    chk("rst_mid_busy", Busy, 0);
    chk("rst_mid_dump", Reg_dump, 0);
    chk("rst_mid_dirty", Dirty, 0);
    tick();
    set_in(0, 0, 0, 2, 6, 1, 0);
    tick();
    set_in(0, 0, 0, 2, 6, 0, 0);
    #1;
    chk("reclear_busy", Busy, 1);
    for (int c = 0; c < 8; c++) tick();
    chk("reclear_done", Busy, 0);

    // Load and Clear_req together: write lands, then gets cleared.
    set_in(1, 7, 16'hA5A5, 7, 0, 1, 0);
    tick();
    set_in(0, 0, 0, 7, 0, 0, 0);
    for (int j = 1; j <= 7; j++) begin
      #1;
      chk($sformatf("lc_r7_c%0d", j), Data_out[15:0], 16'hA5A5);
      tick();
    end
    tick();
    chk("lc_end_busy", Busy, 0);
    chk("lc_end_r7", Data_out[15:0], 16'h0000);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, NR - 1)),
             16'($urandom), int'($urandom_range(0, NR - 1)),
             int'($urandom_range(0, NR - 1)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 8, register count (power of two, >=2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports.
REQ-004 SHALL derive localparam ADDR_W = $clog2(NUM_REGS).
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-006 Clk  in  1  rising-edge clock.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 Load  in  1  write enable.
REQ-009 Write_sel  in  ADDR_W  write address.
REQ-010 Data_In  in  DATA_W  write data.
REQ-011 Read_sel  in  NUM_RD*ADDR_W  packed read addresses; port k uses slice k.
REQ-012 Data_out  out  NUM_RD*DATA_W  packed read data; port k uses slice k.
REQ-013 Clear_req  in  1  request a sequential clear of all registers.
REQ-014 Busy  out  1  high while the clear sequence runs.
REQ-015 Dirty  out  NUM_REGS  bit i is high when register i was written since its last clear or reset.
REQ-016 Reg_dump  out  NUM_REGS*DATA_W  all register contents, for debug display.

Function
REQ-017 SHALL make reads combinational: Data_out slice k equals the register addressed by Read_sel slice k in the same cycle.
REQ-018 SHALL write Data_In to register Write_sel on the rising edge when Load=1 and Busy=0, and set Dirty[Write_sel].
REQ-019 SHALL ignore Load while Busy=1: no register change and no Dirty change.
REQ-020 SHALL implement an FSM with states IDLE and CLEAR, plus a clear counter of width ADDR_W.
REQ-021 SHALL, in IDLE with Clear_req=1, move to CLEAR on the next edge with the counter set to 0; Busy goes high on that edge.
REQ-022 SHALL, in CLEAR, zero register[counter] and Dirty[counter] on each edge, then increment the counter.
REQ-023 SHALL return to IDLE on the edge that clears register NUM_REGS-1; Busy is high for exactly NUM_REGS cycles.
REQ-024 SHALL ignore Clear_req while in CLEAR: no restart and no extension.
REQ-025 SHALL, when Load and Clear_req are both high in IDLE, commit the write first; the register is then zeroed by the sequence.
REQ-026 SHALL let reads during CLEAR return current contents: registers already cleared read 0, the rest keep their old values.
REQ-027 SHALL let Reg_dump and Dirty reflect registered state only, never bypassed data.

Reset
REQ-028 SHALL, on Reset=1 at a rising edge, set all registers to 0, Dirty to 0, the FSM to IDLE, the counter to 0 and Busy to 0.
REQ-029 SHALL let Reset take priority over Load, Clear_req and an in-progress CLEAR; a reset mid-clear aborts the sequence.

Configuration
REQ-030 SHALL gate write-to-read forwarding with macro REGFILE_BYPASS_EN.
REQ-031 With REGFILE_BYPASS_EN defined: when Load=1, Busy=0 and Read_sel slice k equals Write_sel, Data_out slice k SHALL equal Data_In in the same cycle.
REQ-032 Without REGFILE_BYPASS_EN: Data_out SHALL always return the stored value; a write becomes visible the cycle after the edge.

Structure
REQ-033 SHALL place the FSM state enum (IDLE, CLEAR) and the default DATA_W/NUM_REGS constants in shared package regfile_pkg.
REQ-034 SHALL place the FSM and counter in sub-module regfile_clr_seq, which outputs Busy, a clear strobe and the clear index.

Verification
REQ-035 Reset, then Load=1, Write_sel=3, Data_In=16'hDC03; next cycle Read_sel port0=3 -> Data_out0=16'hDC03, Dirty=8'b0000_1000.
REQ-036 Same write with Read_sel port1=3 in the same cycle -> Data_out1=16'hDC03 with REGFILE_BYPASS_EN defined; old value 16'h0000 without it.
REQ-037 Fill R0..R7 with 16'h1111..16'h8888, pulse Clear_req -> Busy high for exactly 8 cycles; R0 reads 0 after the first clear edge while R7 still reads 16'h8888; at the end all registers are 0 and Dirty=0.
REQ-038 During CLEAR, Load=1, Write_sel=5, Data_In=16'hBEEF -> R5 ends at 0; Dirty[5]=0.
REQ-039 Reset asserted on the 3rd clear cycle -> next cycle Busy=0, FSM in IDLE, all registers 0; a new Clear_req is accepted normally.
REQ-040 Load and Clear_req together in IDLE with Write_sel=7, Data_In=16'hA5A5 -> R7 reads 16'hA5A5 during the first 7 Busy cycles, then 0.
